axi_lite_rr_arbiter: RTL and testbench
======================================

# axi_lite_rr_arbiter

- Fair round-robin arbiter for the N-to-1 AXI-Lite bridge.
- Grants the shared slave port to one master for writes and, independently, one master for reads.
- Holds each grant from request through the response handshake, so transactions never interleave on a channel.
- The bridge muxes its AW/W/B and AR/R channels from the grant vectors produced here.

## Interface
- N_MASTERS, 4: number of requesting masters, 2..16.
- TIMEOUT_CYCLES, 256: watchdog limit in cycles per granted transaction. Used only with AXIL_ARB_TIMEOUT_EN; must be ≥ 2.
- IDX_W: derived, $clog2(N_MASTERS). Not user-set.

Ports:
- clk  in  1  single clock, all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_req  in  N_MASTERS  per-master aw_valid.
- rd_req  in  N_MASTERS  per-master ar_valid.
- b_done  in  1  slave-side b_valid && b_ready.
- r_done  in  1  slave-side r_valid && r_ready.
- wr_gnt  out  N_MASTERS  one-hot write grant, registered.
- wr_gnt_idx  out  IDX_W  binary index of write winner.
- wr_busy  out  1  write channel owned.
- rd_gnt  out  N_MASTERS  one-hot read grant, registered.
- rd_gnt_idx  out  IDX_W  binary index of read winner.
- rd_busy  out  1  read channel owned.
- wr_timeout  out  1  one-cycle pulse on write watchdog expiry.
- rd_timeout  out  1  one-cycle pulse on read watchdog expiry.

## Operation
- Two identical, fully independent channel engines, write and read. No coupling; both may be granted in the same cycle.
- Per-engine state machine:
  - IDLE: if any req bit is set, select the first set bit scanning upward from ptr with wrap (ptr, ptr+1, …, N-1, 0, …). Register the grant and go to OWN.
  - OWN: grant held constant. Req bits are ignored, including a requester dropping valid (a protocol violation, not checked here).
    - On done: clear the grant, set ptr = winner+1 mod N_MASTERS, return to IDLE.
- Round-robin pointer:
  - ptr resets to 0.
  - Wrap: a winner at N-1 sets ptr to 0.
  - Only a completed (or timed-out) grant advances ptr.
- busy = (state == OWN). gnt is nonzero only in OWN. gnt_idx holds the last winner in IDLE. wr_gnt_idx/rd_gnt_idx are 0 after reset.
- A done pulse seen while IDLE is ignored (spurious).

## Timing
- Reset (async assert, synchronous release): all gnt = 0, busy = 0, gnt_idx = 0, timeout = 0, ptr = 0, state IDLE. Takes effect immediately, including mid-OWN; the in-flight transaction is abandoned.
- Grant latency: req sampled set at edge k gives gnt/busy high after edge k.
- Release: done sampled at edge k gives gnt/busy low after edge k.
- Re-arbitration: at the earliest after edge k+1. Exactly one IDLE cycle always separates back-to-back grants on a channel, even if requests are pending when done arrives.
- Done in the same cycle as the grant register update cannot occur; done is honoured only in OWN.
- Minimum transaction occupancy is 1 cycle in OWN, i.e. done on the first OWN cycle.

## Configuration
- Macro AXIL_ARB_TIMEOUT_EN.
- Defined: each engine has a counter of width $clog2(TIMEOUT_CYCLES+1).
  - Cleared on entry to OWN; increments each OWN cycle without done.
  - When the count reaches TIMEOUT_CYCLES-1 with no done, the next edge releases the grant exactly like done: ptr advances, state returns to IDLE.
  - wr_timeout/rd_timeout pulse high for that one cycle, concurrent with gnt falling.
  - Done on the expiry cycle takes priority: no timeout pulse.
- Undefined: no counter; wr_timeout/rd_timeout tied 0; grants persist until done.

## Test plan
- Single requester: wr_req=4'b0100 → wr_gnt=4'b0100, wr_gnt_idx=2 one cycle later. b_done after 3 cycles → gnt 0 next cycle; ptr=3.
- Rotation: wr_req=4'b1111 held, b_done one cycle after each grant → grant order 0,1,2,3,0, with one idle cycle between grants.
- Wrap and skip: ptr=3, wr_req=4'b0110 → master 1 granted, then 2. Master 0 is never granted.
- Independence: wr_req=4'b0001 and rd_req=4'b1000 in the same cycle → wr_gnt=0001 and rd_gnt=1000 concurrently. r_done leaves the write grant untouched.
- Reset mid-OWN: rd_gnt=0010, rst_n low asynchronously → rd_gnt=0, rd_busy=0 immediately. After release, with rd_req=4'b0011, master 0 wins (ptr=0).
- With AXIL_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8: grant master 1 with no b_done → after 8 OWN cycles, wr_timeout pulses one cycle and wr_gnt=0; the next grant goes to master 2 if requesting. Without the macro, the grant is still held at 100 cycles.

Source files
------------

// File: rtl/axi_lite_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// axi_lite_rr_arbiter_if
//   Handshake bundle between the AXI-Lite bridge datapath and its round-robin
//   arbiter.
//
//   Parameters:
//     N_MASTERS   number of requesting masters (2..16)
//
//   Signals:
//     wr_req / rd_req          per-master aw_valid / ar_valid
//     b_done / r_done          slave-side response handshake completed
//     wr_gnt / rd_gnt          one-hot registered grants
//     wr_gnt_idx / rd_gnt_idx  binary index of the current (or last) winner
//     wr_busy / rd_busy        channel currently owned
//     wr_timeout / rd_timeout  one-cycle watchdog expiry pulse
//
//   Modports:
//     master  bridge side: drives requests and done strobes, observes grants
//     slave   arbiter side: consumes requests and done strobes, drives grants
// ---------------------------------------------------------------------------
interface axi_lite_rr_arbiter_if #(
   parameter int unsigned N_MASTERS = 4
);
   localparam int unsigned IDX_W = $clog2(N_MASTERS);

   logic [N_MASTERS-1:0] wr_req;
   logic [N_MASTERS-1:0] rd_req;
   logic                 b_done;
   logic                 r_done;
   logic [N_MASTERS-1:0] wr_gnt;
   logic [IDX_W-1:0]     wr_gnt_idx;
   logic                 wr_busy;
   logic [N_MASTERS-1:0] rd_gnt;
   logic [IDX_W-1:0]     rd_gnt_idx;
   logic                 rd_busy;
   logic                 wr_timeout;
   logic                 rd_timeout;

   modport master (
      output wr_req, rd_req, b_done, r_done,
      input  wr_gnt, wr_gnt_idx, wr_busy, rd_gnt, rd_gnt_idx, rd_busy,
      input  wr_timeout, rd_timeout
   );

   modport slave (
      input  wr_req, rd_req, b_done, r_done,
      output wr_gnt, wr_gnt_idx, wr_busy, rd_gnt, rd_gnt_idx, rd_busy,
      output wr_timeout, rd_timeout
   );
endinterface

// File: rtl/axi_lite_rr_arbiter.sv
// ---------------------------------------------------------------------------
// axi_lite_rr_arbiter
//   Fair round-robin arbiter for the N-to-1 AXI-Lite bridge. Two independent
//   engines (write, read) each grant the shared slave port to one master and
//   hold that grant until the response handshake completes, so transactions
//   never interleave on a channel.
//
//   Parameters:
//     N_MASTERS       number of masters, 2..16
//     TIMEOUT_CYCLES  watchdog limit in OWN cycles (>= 2), watchdog builds only
//
//   Ports:
//     clk    single clock, posedge
//     rst_n  asynchronous active-low reset
//     bus    axi_lite_rr_arbiter_if.slave: requests/done in, grants out
//
//   Build option:
//     AXIL_ARB_TIMEOUT_EN  when defined, each engine has a watchdog that
//                          releases a grant after TIMEOUT_CYCLES OWN cycles
//                          without done and pulses wr_timeout/rd_timeout.
//                          When undefined, timeouts are tied low.
// ---------------------------------------------------------------------------
module axi_lite_rr_arbiter #(
   parameter int unsigned N_MASTERS      = 4,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input logic                  clk,
   input logic                  rst_n,
   axi_lite_rr_arbiter_if.slave bus
);
   localparam int unsigned IDX_W = $clog2(N_MASTERS);

   if (N_MASTERS < 2 || N_MASTERS > 16) begin : g_bad_n_masters
      $error("N_MASTERS must be in 2..16");
   end
   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be >= 2");
   end

   typedef enum logic [0:0] {
      StIdle = 1'b0,
      StOwn  = 1'b1
   } state_e;

   // Channel 0 = write, channel 1 = read.
   logic [N_MASTERS-1:0] req     [2];
   logic                 done    [2];
   logic [N_MASTERS-1:0] gnt     [2];
   logic [IDX_W-1:0]     gnt_idx [2];
   logic                 busy    [2];
   logic                 timeout [2];

   assign req[0]  = bus.wr_req;
   assign req[1]  = bus.rd_req;
   assign done[0] = bus.b_done;
   assign done[1] = bus.r_done;

   assign bus.wr_gnt     = gnt[0];
   assign bus.wr_gnt_idx = gnt_idx[0];
   assign bus.wr_busy    = busy[0];
   assign bus.wr_timeout = timeout[0];
   assign bus.rd_gnt     = gnt[1];
   assign bus.rd_gnt_idx = gnt_idx[1];
   assign bus.rd_busy    = busy[1];
   assign bus.rd_timeout = timeout[1];

   for (genvar ch = 0; ch < 2; ch++) begin : g_chan
      state_e               state_q, state_d;
      logic [IDX_W-1:0]     ptr_q, ptr_d;
      logic [IDX_W-1:0]     idx_q, idx_d;
      logic [N_MASTERS-1:0] gnt_q, gnt_d;
      logic [IDX_W-1:0]     win;
      logic                 found;
      logic                 expire;

      // First requester at or above ptr, wrapping past N_MASTERS-1 to 0.
      always_comb begin
         int unsigned cand;
         found = 1'b0;
         win   = ptr_q;
         cand  = 0;
         for (int unsigned off = 0; off < N_MASTERS; off++) begin
            cand = (32'(ptr_q) + off) % N_MASTERS;
            if (!found && req[ch][IDX_W'(cand)]) begin
               found = 1'b1;
               win   = IDX_W'(cand);
            end
         end
      end

      always_comb begin
         state_d = state_q;
         ptr_d   = ptr_q;
         idx_d   = idx_q;
         gnt_d   = gnt_q;
         unique case (state_q)
            StIdle: begin
               // A done strobe here is spurious and deliberately ignored.
               if (found) begin
                  state_d    = StOwn;
                  idx_d      = win;
                  gnt_d      = '0;
                  gnt_d[win] = 1'b1;
               end
            end
            StOwn: begin
               // Requests are ignored while owned; only completion releases.
               if (done[ch] || expire) begin
                  state_d = StIdle;
                  gnt_d   = '0;
                  ptr_d   = (idx_q == IDX_W'(N_MASTERS - 1)) ? '0 : idx_q + 1'b1;
               end
            end
            default: begin
               state_d = StIdle;
               gnt_d   = '0;
            end
         endcase
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            idx_q   <= '0;
            gnt_q   <= '0;
         end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
         end
      end

`ifdef AXIL_ARB_TIMEOUT_EN
      localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             timeout_q, timeout_d;

      // cnt_q counts completed OWN cycles; the last allowed cycle sees T-1.
      assign expire = (state_q == StOwn) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

      always_comb begin
         cnt_d     = '0;
         timeout_d = 1'b0;
         if (state_q == StOwn) begin
            if (!done[ch] && !expire) begin
               cnt_d = cnt_q + 1'b1;
            end
            // Done on the expiry cycle wins: no pulse.
            timeout_d = expire && !done[ch];
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
         end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
         end
      end

      assign timeout[ch] = timeout_q;
`else
      assign expire      = 1'b0;
      assign timeout[ch] = 1'b0;
`endif

      assign gnt[ch]     = gnt_q;
      assign gnt_idx[ch] = idx_q;
      assign busy[ch]    = (state_q == StOwn);
   end
endmodule

// File: tb/tb_axi_lite_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_rr_arbiter
//   Self-checking bench: directed scenarios followed by random requests and
//   done strobes, compared every cycle against a transaction-level model of
//   the two channel arbiters.
// ---------------------------------------------------------------------------
module tb_axi_lite_rr_arbiter;
   localparam int unsigned N = 4;
   localparam int unsigned T = 8;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   axi_lite_rr_arbiter_if #(.N_MASTERS(N)) bus ();

   axi_lite_rr_arbiter #(
      .N_MASTERS      (N),
      .TIMEOUT_CYCLES (T)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model, per channel (0 = write, 1 = read).
   bit          m_own [2];
   int unsigned m_ptr [2];
   int unsigned m_idx [2];
   int unsigned m_cnt [2];  // OWN cycles already completed
   bit          m_to  [2];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int unsigned pick(input logic [N-1:0] r, input int unsigned ptr);
      for (int unsigned k = 0; k < N; k++) begin
         if (r[(ptr + k) % N]) return (ptr + k) % N;
      end
      return 0;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < 2; c++) begin
         m_own[c] = 0;
         m_ptr[c] = 0;
         m_idx[c] = 0;
         m_cnt[c] = 0;
         m_to[c]  = 0;
      end
   endtask

   task automatic model_chan(input int c, input logic [N-1:0] r, input logic d);
      bit expire;
      expire  = 0;
      m_to[c] = 0;
      if (m_own[c]) begin
`ifdef AXIL_ARB_TIMEOUT_EN
         expire = (m_cnt[c] + 1 == T);
`endif
         if (d || expire) begin
            m_own[c] = 0;
            m_ptr[c] = (m_idx[c] + 1) % N;
            m_to[c]  = expire && !d;
         end else begin
            m_cnt[c]++;
         end
      end else if (r != '0) begin
         m_idx[c] = pick(r, m_ptr[c]);
         m_own[c] = 1;
         m_cnt[c] = 0;
      end
   endtask

   task automatic check_outputs();
      check("wr_gnt", 32'(bus.wr_gnt), m_own[0] ? (32'd1 << m_idx[0]) : 32'd0);
      check("wr_gnt_idx", 32'(bus.wr_gnt_idx), m_idx[0]);
      check("wr_busy", 32'(bus.wr_busy), 32'(m_own[0]));
      check("wr_timeout", 32'(bus.wr_timeout), 32'(m_to[0]));
      check("rd_gnt", 32'(bus.rd_gnt), m_own[1] ? (32'd1 << m_idx[1]) : 32'd0);
      check("rd_gnt_idx", 32'(bus.rd_gnt_idx), m_idx[1]);
      check("rd_busy", 32'(bus.rd_busy), 32'(m_own[1]));
      check("rd_timeout", 32'(bus.rd_timeout), 32'(m_to[1]));
   endtask

   // Advance one clock: model consumes the inputs the DUT is about to sample.
   task automatic step();
      model_chan(0, bus.wr_req, bus.b_done);
      model_chan(1, bus.rd_req, bus.r_done);
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   initial begin
      int  waited;
      bit  seen;

      rst_n      = 1'b0;
      bus.wr_req = '0;
      bus.rd_req = '0;
      bus.b_done = 1'b0;
      bus.r_done = 1'b0;
      model_reset();
      #1;
      check_outputs();
      @(negedge clk);
      rst_n = 1'b1;

      // Rotation: all requesting, done right after each grant.
      bus.wr_req = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         step();
         check("rot_idx", 32'(bus.wr_gnt_idx), g % 4);
         check("rot_busy", 32'(bus.wr_busy), 1);
         bus.b_done = 1'b1;
         step();
         bus.b_done = 1'b0;
         check("rot_gap", 32'(bus.wr_busy), 0);
      end
      bus.wr_req = '0;

      // Single requester held for 3 OWN cycles.
      bus.wr_req = 4'b0100;
      step();
      check("single_gnt", 32'(bus.wr_gnt), 32'h4);
      check("single_idx", 32'(bus.wr_gnt_idx), 2);
      bus.wr_req = '0;
      step();
      step();
      bus.b_done = 1'b1;
      step();
      bus.b_done = 1'b0;
      check("single_release", 32'(bus.wr_gnt), 0);

      // Wrap and skip from ptr=3: master 1 then 2, never 0.
      bus.wr_req = 4'b0110;
      step();
      check("wrap_first", 32'(bus.wr_gnt_idx), 1);
      bus.b_done = 1'b1;
      step();
      bus.b_done = 1'b0;
      step();
      check("wrap_second", 32'(bus.wr_gnt_idx), 2);
      bus.b_done = 1'b1;
      bus.wr_req = '0;
      step();
      bus.b_done = 1'b0;

      // Channel independence.
      bus.wr_req = 4'b0001;
      bus.rd_req = 4'b1000;
      step();
      check("indep_wr", 32'(bus.wr_gnt), 32'h1);
      check("indep_rd", 32'(bus.rd_gnt), 32'h8);
      bus.wr_req = '0;
      bus.rd_req = '0;
      bus.r_done = 1'b1;
      step();
      bus.r_done = 1'b0;
      check("indep_rd_rel", 32'(bus.rd_gnt), 0);
      check("indep_wr_kept", 32'(bus.wr_gnt), 32'h1);
      bus.b_done = 1'b1;
      step();
      bus.b_done = 1'b0;

      // Asynchronous reset while the read channel is owned.
      bus.rd_req = 4'b0010;
      step();
      check("rst_pre_gnt", 32'(bus.rd_gnt), 32'h2);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check("rst_async_gnt", 32'(bus.rd_gnt), 0);
      check("rst_async_busy", 32'(bus.rd_busy), 0);
      check("rst_async_idx", 32'(bus.rd_gnt_idx), 0);
      bus.rd_req = 4'b0011;
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check("rst_ptr0_gnt", 32'(bus.rd_gnt), 32'h1);
      bus.rd_req = '0;
      bus.r_done = 1'b1;
      step();
      bus.r_done = 1'b0;

      // Watchdog: master 1 granted, never completes.
      bus.wr_req = 4'b0010;
      step();
      check("wd_gnt", 32'(bus.wr_gnt), 32'h2);
      bus.wr_req = 4'b0110;
`ifdef AXIL_ARB_TIMEOUT_EN
      waited = 0;
      seen   = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         step();
         waited++;
         if (bus.wr_timeout) seen = 1;
      end
      check("wd_seen", 32'(seen), 1);
      check("wd_cycles", waited, T);
      check("wd_gnt_drop", 32'(bus.wr_gnt), 0);
      step();
      check("wd_pulse_len", 32'(bus.wr_timeout), 0);
      check("wd_next", 32'(bus.wr_gnt), 32'h4);
`else
      waited = 0;
      seen   = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         waited++;
         if (bus.wr_timeout) seen = 1;
      end
      check("hold_gnt", 32'(bus.wr_gnt), 32'h2);
      check("hold_busy", 32'(bus.wr_busy), 1);
      check("hold_no_to", 32'(seen), 0);
      check("hold_cycles", waited, 100);
`endif
      bus.wr_req = '0;
      bus.b_done = 1'b1;
      step();
      bus.b_done = 1'b0;

      // Random traffic, including spurious done strobes while idle.
      for (int i = 0; i < 1500; i++) begin
         bus.wr_req = N'($urandom);
         bus.rd_req = N'($urandom);
         bus.b_done = ($urandom_range(0, 3) == 0);
         bus.r_done = ($urandom_range(0, 3) == 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
